// File: rtl/quadrature_decoder.sv
// 4x quadrature decoder: signed position count, per-edge step/direction,
// windowed signed velocity and a sticky flag for illegal Gray-code jumps.
module quadrature_decoder #(
    parameter int POS_W  = 32,
    parameter int VEL_W  = 16,
    parameter int WINDOW = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    clear,
    output logic signed [POS_W-1:0] position,
    output logic                    step,
    output logic                    dir,
    output logic signed [VEL_W-1:0] velocity,
    output logic                    vel_valid,
    output logic                    err
);

    localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic signed [VEL_W-1:0] VEL_MAX  = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W-1:0] VEL_MIN  = {1'b1, {(VEL_W-1){1'b0}}};

    logic [1:0]              cur_q, prev_q;
    logic                    valid_q, primed_q;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    step_q, step_d;
    logic                    dir_q, dir_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic                    vel_valid_q, vel_valid_d;
    logic                    err_q, err_d;
    logic signed [VEL_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    fwd, rev, illegal;
    logic signed [VEL_W-1:0] acc_sum;

    // Transition table on {prev, cur}; nothing decodes until prev holds a real sample.
    always_comb begin
        fwd     = 1'b0;
        rev     = 1'b0;
        illegal = 1'b0;
        if (primed_q) begin
            case ({prev_q, cur_q})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd     = 1'b1;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev     = 1'b1;
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
                default: ;
            endcase
        end
    end

    // Saturating accumulate including this cycle's edge.
    always_comb begin
        acc_sum = acc_q;
        if (fwd && (acc_q != VEL_MAX)) begin
            acc_sum = acc_q + VEL_W'(1);
        end else if (rev && (acc_q != VEL_MIN)) begin
            acc_sum = acc_q - VEL_W'(1);
        end
    end

    always_comb begin
        pos_d       = pos_q;
        step_d      = 1'b0;
        dir_d       = dir_q;
        err_d       = err_q;
        vel_d       = vel_q;
        vel_valid_d = 1'b0;
        acc_d       = acc_q;
        cnt_d       = cnt_q + CNT_W'(1);
        if (clear) begin
            pos_d = '0;
            err_d = 1'b0;
            vel_d = '0;
            acc_d = '0;
            cnt_d = '0;
        end else begin
            if (fwd) begin
                pos_d  = pos_q + POS_W'(1);
                step_d = 1'b1;
                dir_d  = 1'b1;
            end else if (rev) begin
                pos_d  = pos_q - POS_W'(1);
                step_d = 1'b1;
                dir_d  = 1'b0;
            end
            if (illegal) begin
                err_d = 1'b1;
            end
            // Edges in the terminal cycle close into this window's result.
            if (cnt_q == CNT_LAST) begin
                vel_d       = acc_sum;
                vel_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q       <= 2'b00;
            prev_q      <= 2'b00;
            valid_q     <= 1'b0;
            primed_q    <= 1'b0;
            pos_q       <= '0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            vel_q       <= '0;
            vel_valid_q <= 1'b0;
            err_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            cur_q       <= {enc_a, enc_b};
            prev_q      <= cur_q;
            valid_q     <= 1'b1;
            primed_q    <= valid_q;
            pos_q       <= pos_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            vel_q       <= vel_d;
            vel_valid_q <= vel_valid_d;
            err_q       <= err_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign position  = pos_q;
    assign step      = step_q;
    assign dir       = dir_q;
    assign velocity  = vel_q;
    assign vel_valid = vel_valid_q;
    assign err       = err_q;

endmodule
